// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: mode enum, channel-index width helper and one-hot check shared by stream_mux and rr_arbiter
package stream_mux_pkg;
   typedef enum logic {MUX_SEL_EXT, MUX_SEL_RR} mux_mode_e;
   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
   function automatic logic is_onehot(input logic [15:0] v);
      return (v != '0) && ((v & (v - 16'd1)) == '0);
   endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant over req starting at an internal pointer (clk, reset_n, req, advance -> grant, grant_idx); pointer moves past the winner on advance
module rr_arbiter
   import stream_mux_pkg::*;
#(
   parameter int NUM_CH = 4,
   localparam int CH_W = ch_w(NUM_CH)
)(
   input  logic              clk,
   input  logic              reset_n,
   input  logic [NUM_CH-1:0] req,
   input  logic              advance,
   output logic [NUM_CH-1:0] grant,
   output logic [CH_W-1:0]   grant_idx
);
   logic [CH_W-1:0] ptr;
   logic found;
   int c;
   always_comb begin
      grant = '0;
      grant_idx = '0;
      found = 1'b0;
      c = 0;
      for (int i = 0; i < NUM_CH; i++) begin
         c = (int'(ptr) + i) % NUM_CH;
         if (!found && req[c]) begin
            found = 1'b1;
            grant[c] = 1'b1;
            grant_idx = CH_W'(c);
         end
      end
   end
   always_ff @(posedge clk)
      if (!reset_n) ptr <= '0;
      else if (advance) ptr <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
endmodule

// File: rtl/stream_mux.sv
// stream_mux: NUM_CH:1 valid/ready mux with one output register (clk, reset_n, in_valid_i/in_data_i/in_ready_o, sel_i, out_valid_o/out_data_o/out_ch_o/out_ready_i, sel_err_o)
module stream_mux
   import stream_mux_pkg::*;
#(
   parameter int        NUM_CH = 4,
   parameter int        DATA_W = 1,
   parameter mux_mode_e MODE   = MUX_SEL_EXT,
   localparam int       CH_W   = ch_w(NUM_CH)
)(
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [NUM_CH-1:0]        in_valid_i,
   input  logic [NUM_CH*DATA_W-1:0] in_data_i,
   output logic [NUM_CH-1:0]        in_ready_o,
   input  logic [NUM_CH-1:0]        sel_i,
   output logic                     out_valid_o,
   output logic [DATA_W-1:0]        out_data_o,
   output logic [CH_W-1:0]          out_ch_o,
   input  logic                     out_ready_i,
   output logic                     sel_err_o
);
   logic load_en, hs;
   logic [NUM_CH-1:0] grant;
   logic [CH_W-1:0] grant_idx;
   assign load_en = !out_valid_o || out_ready_i;
   assign in_ready_o = reset_n ? (grant & {NUM_CH{load_en}}) : '0;
   assign hs = |(in_valid_i & in_ready_o);
   generate
      if (MODE == MUX_SEL_RR) begin : g_rr
         rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
            .clk       (clk),
            .reset_n   (reset_n),
            .req       (in_valid_i),
            .advance   (hs),
            .grant     (grant),
            .grant_idx (grant_idx)
         );
      end else begin : g_ext
         // multi-hot select grants nothing, so the index from a multi-hot sel_i is never used
         always_comb begin
            grant = is_onehot(16'(sel_i)) ? sel_i : '0;
            grant_idx = '0;
            for (int i = 0; i < NUM_CH; i++)
               if (sel_i[i]) grant_idx = CH_W'(i);
         end
      end
   endgenerate
   always_ff @(posedge clk)
      if (!reset_n) begin
         out_valid_o <= 1'b0;
         out_data_o  <= '0;
         out_ch_o    <= '0;
         sel_err_o   <= 1'b0;
      end else begin
         sel_err_o <= (MODE == MUX_SEL_EXT) && (sel_i != '0) && !is_onehot(16'(sel_i));
         if (load_en) out_valid_o <= hs;
         if (hs) begin
            out_data_o <= in_data_i[grant_idx*DATA_W +: DATA_W];
            out_ch_o   <= grant_idx;
         end
      end
endmodule

// File: tb/tb_stream_mux.sv
// tb_stream_mux: checks an external-select and a round-robin stream_mux against a behavioural model, directed vectors and a beat scoreboard
module tb_stream_mux;
   import stream_mux_pkg::*;
   logic clk = 0;
   logic reset_n = 0;
   always #5 clk = ~clk;
   logic [3:0] e_valid = 0, e_data = 0, e_sel = 0, e_ready;
   logic e_ordy = 0, e_ovalid, e_odata, e_err;
   logic [1:0] e_ch;
   logic [3:0] r_valid = 0, r_sel = 0, r_ready;
   logic [31:0] r_data = 0;
   logic r_ordy = 0, r_ovalid, r_err;
   logic [7:0] r_odata;
   logic [1:0] r_ch;
   stream_mux #(.NUM_CH(4), .DATA_W(1), .MODE(MUX_SEL_EXT)) u_ext (
      .clk(clk), .reset_n(reset_n), .in_valid_i(e_valid), .in_data_i(e_data), .in_ready_o(e_ready),
      .sel_i(e_sel), .out_valid_o(e_ovalid), .out_data_o(e_odata), .out_ch_o(e_ch),
      .out_ready_i(e_ordy), .sel_err_o(e_err));
   stream_mux #(.NUM_CH(4), .DATA_W(8), .MODE(MUX_SEL_RR)) u_rr (
      .clk(clk), .reset_n(reset_n), .in_valid_i(r_valid), .in_data_i(r_data), .in_ready_o(r_ready),
      .sel_i(r_sel), .out_valid_o(r_ovalid), .out_data_o(r_odata), .out_ch_o(r_ch),
      .out_ready_i(r_ordy), .sel_err_o(r_err));
   int checks = 0, errors = 0;
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
      end
   endtask
   function automatic int rr_pick(input logic [3:0] v, input int p);
      for (int k = 0; k < 4; k++)
         if (v[(p + k) % 4]) return (p + k) % 4;
      return -1;
   endfunction
   function automatic logic [3:0] exp_e_ready(input logic rn, input logic ov, input logic ordy, input logic [3:0] s);
      return (rn && (!ov || ordy) && $countones(s) == 1) ? s : 4'b0;
   endfunction
   function automatic logic [3:0] exp_r_ready(input logic rn, input logic ov, input logic ordy, input logic [3:0] v, input int p);
      int c;
      c = rr_pick(v, p);
      return (rn && (!ov || ordy) && c >= 0) ? 4'(1 << c) : 4'b0;
   endfunction
   logic m_ev = 0, m_ed = 0, m_eerr = 0, m_rv = 0;
   logic [7:0] m_rd = 0;
   int m_ech = 0, m_rch = 0, m_ptr = 0;
   always @(posedge clk) begin
      logic [3:0] g;
      int c;
      if (!reset_n) begin
         m_ev = 0; m_ed = 0; m_ech = 0; m_eerr = 0;
         m_rv = 0; m_rd = 0; m_rch = 0; m_ptr = 0;
      end else begin
         g = exp_e_ready(1'b1, m_ev, e_ordy, e_sel);
         m_eerr = $countones(e_sel) > 1;
         if (!m_ev || e_ordy) begin
            m_ev = |(g & e_valid);
            if (m_ev) begin
               c = rr_pick(g, 0);
               m_ed = e_data[c];
               m_ech = c;
            end
         end
         if (!m_rv || r_ordy) begin
            c = rr_pick(r_valid, m_ptr);
            m_rv = c >= 0;
            if (m_rv) begin
               m_rd = r_data[c*8 +: 8];
               m_rch = c;
               m_ptr = (c + 1) % 4;
            end
         end
      end
   end
   logic [9:0] sb[$];
   always @(negedge clk) begin
      int c;
      chk("e_valid", e_ovalid, m_ev);
      chk("e_err", e_err, m_eerr);
      chk("e_ready", e_ready, exp_e_ready(reset_n, m_ev, e_ordy, e_sel));
      if (m_ev) begin
         chk("e_data", e_odata, m_ed);
         chk("e_ch", e_ch, m_ech);
      end
      chk("r_valid", r_ovalid, m_rv);
      chk("r_err", r_err, 0);
      chk("r_ready", r_ready, exp_r_ready(reset_n, m_rv, r_ordy, r_valid, m_ptr));
      if (m_rv) begin
         chk("r_data", r_odata, m_rd);
         chk("r_ch", r_ch, m_rch);
      end
      chk("ready_onehot", ($countones(r_ready) <= 1) && ($countones(e_ready) <= 1), 1);
      if (!reset_n) sb.delete();
      else begin
         if (r_ovalid && r_ordy) begin
            chk("sb_pending", sb.size() > 0, 1);
            if (sb.size() > 0) chk("sb_beat", {r_ch, r_odata}, sb.pop_front());
         end
         if (|(r_valid & r_ready)) begin
            c = rr_pick(r_ready, 0);
            sb.push_back({2'(c), r_data[c*8 +: 8]});
         end
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   initial begin
      tick();
      tick();
      chk("rst_e_valid", e_ovalid, 0);
      chk("rst_r_valid", r_ovalid, 0);
      chk("rst_r_ready", r_ready, 0);
      reset_n = 1;
      e_data = 4'b0011; e_valid = 4'hF; e_sel = 4'b0010; e_ordy = 1;
      tick();
      chk("ext1_valid", e_ovalid, 1);
      chk("ext1_data", e_odata, 1);
      chk("ext1_ch", e_ch, 1);
      e_sel = 4'b1000;
      tick();
      chk("ext3_data", e_odata, 0);
      chk("ext3_ch", e_ch, 3);
      e_sel = 4'b0110;
      #1 chk("multi_ready", e_ready, 0);
      tick();
      chk("multi_valid", e_ovalid, 0);
      chk("multi_err", e_err, 1);
      e_sel = 4'b0000;
      tick();
      chk("err_pulse_end", e_err, 0);
      chk("zero_sel_valid", e_ovalid, 0);
      r_data = {8'h33, 8'h22, 8'h11, 8'h00}; r_valid = 4'hF; r_ordy = 1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("rr_seq_ch", r_ch, i % 4);
         chk("rr_seq_data", r_odata, (i % 4) * 8'h11);
      end
      r_valid = 4'b0100;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rr_only2_ch", r_ch, 2);
      end
      r_data[23:16] = 8'hA5;
      tick();
      chk("bp_first", r_odata, 8'hA5);
      r_ordy = 0; r_data[23:16] = 8'h5A;
      for (int i = 0; i < 3; i++) begin
         #1 chk("bp_ready", r_ready, 0);
         tick();
         chk("bp_hold", r_odata, 8'hA5);
         chk("bp_hold_valid", r_ovalid, 1);
      end
      r_ordy = 1;
      #1 chk("bp_release_ready", r_ready, 4'b0100);
      tick();
      chk("bp_next", r_odata, 8'h5A);
      chk("bp_next_valid", r_ovalid, 1);
      r_valid = 4'hF;
      tick(); chk("pre_rst_ch3", r_ch, 3);
      tick(); chk("pre_rst_ch0", r_ch, 0);
      tick(); chk("pre_rst_ch1", r_ch, 1);
      reset_n = 0;
      #1 chk("in_rst_ready", r_ready, 0);
      tick();
      chk("rst_valid", r_ovalid, 0);
      chk("rst_data", r_odata, 0);
      chk("rst_ch", r_ch, 0);
      chk("rst_e_data", {e_ovalid, e_odata, e_ch, e_err}, 0);
      reset_n = 1;
      tick();
      chk("post_rst_ch", r_ch, 0);
      chk("post_rst_valid", r_ovalid, 1);
      for (int i = 0; i < 300; i++) begin
         r_valid = 4'($urandom);
         r_data = $urandom;
         r_ordy = ($urandom % 4) != 0;
         r_sel = 4'($urandom);
         e_valid = 4'($urandom);
         e_data = 4'($urandom);
         e_ordy = 1'($urandom);
         e_sel = ($urandom % 3 == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
         tick();
      end
      chk("sb_left", sb.size() <= 1, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/stream_mux.md
STREAM_MUX -- requirements
Module: stream_mux

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter NUM_CH, default 4, giving the number of input channels (legal range 2..16).
REQ-002 The block SHALL have parameter DATA_W, default 1, giving the bits per channel.
REQ-003 The block SHALL have parameter MODE, default MUX_SEL_EXT, selecting MUX_SEL_EXT (external one-hot select) or MUX_SEL_RR (internal round-robin).

Ports (name, direction, width, meaning):
REQ-004 clk  in  1  single clock; all logic SHALL be rising-edge clk.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 in_valid_i  in  NUM_CH  per-channel valid.
REQ-007 in_data_i  in  NUM_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
REQ-008 in_ready_o  out  NUM_CH  per-channel ready.
REQ-009 sel_i  in  NUM_CH  one-hot channel select; used in MUX_SEL_EXT only, ignored in MUX_SEL_RR.
REQ-010 out_valid_o  out  1  output beat valid.
REQ-011 out_data_o  out  DATA_W  selected data.
REQ-012 out_ch_o  out  CH_W  index of the source channel of the current beat.
REQ-013 out_ready_i  in  1  downstream ready.
REQ-014 sel_err_o  out  1  one-cycle pulse flagging a multi-hot sel_i.

Function
REQ-015 The output SHALL be a single register stage: load_en = !out_valid_o || out_ready_i.
- full throughput of one beat per cycle.
- latency of exactly 1 cycle from input handshake to out_valid_o.
REQ-016 Input channel k SHALL handshake when in_valid_i[k] && in_ready_o[k].
- in_ready_o = grant & {NUM_CH{load_en}}.
- at most one in_ready_o bit is high in any cycle.
REQ-017 MUX_SEL_EXT grant SHALL equal sel_i when sel_i is one-hot.
- sel_i all-zero: no grant, no error.
- sel_i multi-hot: no grant; sel_err_o SHALL be high on the next cycle.
REQ-018 MUX_SEL_EXT SHALL assert in_ready_o[k] even when in_valid_i[k]=0; no transfer occurs in that case.
REQ-019 MUX_SEL_RR grant SHALL go to the first channel with in_valid_i set, searching upward from pointer rr_ptr with wrap from NUM_CH-1 to 0.
- no valid channel: no grant.
REQ-020 rr_ptr SHALL update to (granted index + 1) mod NUM_CH only on a completed input handshake; otherwise rr_ptr SHALL hold.
REQ-021 On handshake, out_data_o and out_ch_o SHALL load the granted channel's data and index; out_valid_o SHALL be set.
REQ-022 When load_en is high and there is no handshake, out_valid_o SHALL clear.
REQ-023 While out_valid_o && !out_ready_i, out_data_o and out_ch_o SHALL be held stable.
REQ-024 Simultaneous output drain and input accept SHALL replace the beat with no bubble.
REQ-025 sel_err_o SHALL be 0 in MUX_SEL_RR.

Reset
REQ-026 While reset_n=0 at a clk edge, the block SHALL force out_valid_o=0, out_data_o=0, out_ch_o=0, sel_err_o=0 and rr_ptr=0.
REQ-027 in_ready_o SHALL be 0 during reset.
REQ-028 Reset mid-transfer SHALL discard the held beat, and the first post-reset RR grant SHALL start from channel 0.

Structure
REQ-029 Package stream_mux_pkg SHALL hold:
- enum mux_mode_e {MUX_SEL_EXT, MUX_SEL_RR}.
- CH_W = $clog2(NUM_CH) helper function.
- one-hot check function.
REQ-030 Round-robin selection SHALL live in sub-module rr_arbiter (NUM_CH param; inputs req, advance; outputs grant, grant_idx); it is instantiated only when MODE==MUX_SEL_RR.

Verification
REQ-031 EXT, NUM_CH=4, DATA_W=1, in_data_i=4'b0011, in_valid_i=4'hF, sel_i=4'b0010, out_ready_i=1 -> next cycle out_valid_o=1, out_data_o=1, out_ch_o=1.
REQ-032 EXT, same data, sel_i=4'b1000 -> out_data_o=0, out_ch_o=3; sel_i=4'b0110 -> in_ready_o=0, out_valid_o=0, and sel_err_o=1 for exactly one cycle.
REQ-033 RR, NUM_CH=4, DATA_W=8, all valid, out_ready_i=1 -> out_ch_o sequence 0,1,2,3,0 on consecutive cycles; with only ch2 valid -> every beat has out_ch_o=2.
REQ-034 Backpressure: out_ready_i=0 for 3 cycles with beat 0xA5 held -> out_data_o stays 0xA5 and in_ready_o=0; on release the next beat follows with no bubble.
REQ-035 Reset: assert reset_n=0 while out_valid_o=1 and rr_ptr=2 -> next cycle all outputs 0; after release, the first grant with all channels valid is ch0.
REQ-036 Random-stress scoreboard: per-channel order is preserved, no beat is lost or duplicated, and at most one in_ready_o bit is high per cycle.
